// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock controller.
// Watches the 2-bit sync headers coming out of the RX gearbox, asks the gearbox for a bit slip
// until the headers line up, and reports block lock to the descrambler/decoder.
// Optional slip/lock statistics outputs are built in when RX_BLOCK_LOCK_STATS_EN is defined.
module rx_block_lock #(
  parameter int unsigned SH_CNT_MAX       = 64,
  parameter int unsigned SH_INVALID_MAX   = 16,
  parameter int unsigned SLIP_WAIT_CYCLES = 4   // 1..255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_header,
  input  logic        i_header_valid,
  output logic        o_slip,
  output logic        o_block_lock
`ifdef RX_BLOCK_LOCK_STATS_EN
  ,
  output logic [15:0] o_slip_count,
  output logic        o_lock_lost
`endif
);

  localparam int unsigned ShCntW  = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned ShInvW  = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned WaitW   = 8;

  typedef enum logic [1:0] {
    StResetCnt,
    StTestSh,
    StSlip,
    StSlipWait
  } state_e;

  state_e              state_q, state_d;
  logic [ShCntW-1:0]   sh_cnt_q, sh_cnt_d;
  logic [ShInvW-1:0]   sh_inv_q, sh_inv_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                slip_q, slip_d;
  logic                lock_q, lock_d;
  logic                hdr_ok;

  // A sync header is legal only when its two bits differ (01 or 10).
  assign hdr_ok = i_header[1] ^ i_header[0];

  // Next-state logic; window decisions use the counts already updated by the current header.
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    wait_d   = wait_q;
    slip_d   = 1'b0;
    lock_d   = lock_q;
    unique case (state_q)
      StResetCnt: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        state_d  = StTestSh;
      end
      StTestSh: begin
        if (i_header_valid) begin
          sh_cnt_d = sh_cnt_q + ShCntW'(1);
          if (!hdr_ok) begin
            sh_inv_d = sh_inv_q + ShInvW'(1);
          end
          if (!lock_q) begin
            if (!hdr_ok) begin
              state_d = StSlip;
            end else if (sh_cnt_d == ShCntW'(SH_CNT_MAX)) begin
              lock_d  = 1'b1;
              state_d = StResetCnt;
            end
          end else begin
            // Too many bad headers wins over a window that completes on the same header.
            if (sh_inv_d == ShInvW'(SH_INVALID_MAX)) begin
              lock_d  = 1'b0;
              state_d = StSlip;
            end else if (sh_cnt_d == ShCntW'(SH_CNT_MAX)) begin
              state_d = StResetCnt;
            end
          end
        end
      end
      StSlip: begin
        slip_d  = 1'b1;
        lock_d  = 1'b0;
        wait_d  = WaitW'(SLIP_WAIT_CYCLES);
        state_d = StSlipWait;
      end
      StSlipWait: begin
        // Headers are meaningless while the gearbox re-aligns, so they are not looked at.
        wait_d = wait_q - WaitW'(1);
        if (wait_d == '0) begin
          state_d = StResetCnt;
        end
      end
      default: state_d = StResetCnt;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StResetCnt;
      sh_cnt_q <= '0;
      sh_inv_q <= '0;
      wait_q   <= '0;
      slip_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      sh_inv_q <= sh_inv_d;
      wait_q   <= wait_d;
      slip_q   <= slip_d;
      lock_q   <= lock_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;

`ifdef RX_BLOCK_LOCK_STATS_EN
  logic [15:0] slip_cnt_q;
  logic        lock_lost_q;

  // Saturating slip counter and a pulse on every loss of lock (reset does not count as a loss).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slip_cnt_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      if (slip_d && (slip_cnt_q != 16'hFFFF)) begin
        slip_cnt_q <= slip_cnt_q + 16'd1;
      end
      lock_lost_q <= lock_q & ~lock_d;
    end
  end

  assign o_slip_count = slip_cnt_q;
  assign o_lock_lost  = lock_lost_q;
`endif

endmodule

// File: tb/tb_rx_block_lock.sv
// Table-driven bench for rx_block_lock: each record holds the inputs for one clock edge and the
// outputs expected just after that edge.
module tb_rx_block_lock;

  logic       clk;
  logic       rst;
  logic [1:0] hdr;
  logic       vld;
  logic       slip;
  logic       lock;
`ifdef RX_BLOCK_LOCK_STATS_EN
  logic [15:0] slip_count;
  logic        lock_lost;
`endif

  rx_block_lock dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_header       (hdr),
    .i_header_valid (vld),
    .o_slip         (slip),
    .o_block_lock   (lock)
`ifdef RX_BLOCK_LOCK_STATS_EN
    ,
    .o_slip_count   (slip_count),
    .o_lock_lost    (lock_lost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] hdr;
    logic       exp_slip;
    logic       exp_lock;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  task automatic add(input logic r, input logic v, input logic [1:0] h, input logic es,
                     input logic el, input string t);
    vec_t e;
    e.rst = r; e.vld = v; e.hdr = h; e.exp_slip = es; e.exp_lock = el; e.tag = t;
    vecs.push_back(e);
  endtask

  // Clean headers alternate 01/10; lock is expected only on the last one when last_locks is set.
  task automatic add_clean(input int n, input logic locked, input logic last_locks,
                           input string t);
    for (int k = 0; k < n; k++) begin
      add(1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0,
          locked | (last_locks & (k == n - 1)), t);
    end
  endtask

  // Slip cycle followed by the wait cycles and the counter-clear cycle, fed strobed junk.
  task automatic add_slip_seq(input string t);
    add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, {t, "_slip"});
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, {t, "_wait"});
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, {t, "_rcnt"});
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic        prev_lock;
    logic [15:0] exp_cnt;
    logic        exp_lost;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    vld   = 1'b0;
    hdr   = 2'b00;

    // Reset, then a counter-clear cycle that must not sample the strobed bad header.
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "reset");
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "reset");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "rcnt_ignore");
    // 64 clean headers -> lock right after the 64th.
    add_clean(64, 1'b0, 1'b1, "acquire");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, "rcnt_locked");
    // Locked window with 15 bad headers at its end: lock held, no slip.
    add_clean(49, 1'b1, 1'b0, "win15_good");
    for (int k = 0; k < 15; k++) add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, "win15_bad");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, "rcnt_win15");
    // Locked, 16th bad header in a window drops lock, then exactly one slip.
    add_clean(5, 1'b1, 1'b0, "loss_good");
    for (int k = 0; k < 15; k++) add(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, "loss_bad");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "loss_16th");
    add_slip_seq("loss");
    // Unlocked: 10 good then one bad -> slip, wait, then counting restarts from 0.
    add_clean(10, 1'b0, 1'b0, "unl_good");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "unl_bad");
    add_slip_seq("unl");
    add_clean(64, 1'b0, 1'b1, "relock");
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, "rcnt_relock");
    // Strobe toggling: unstrobed bad values are ignored, lock after the 64th strobed header.
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "reset2");
    add(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "rcnt2");
    for (int k = 0; k < 64; k++) begin
      add(1'b0, 1'b1, 2'b01, 1'b0, k == 63, "strobe_on");
      add(1'b0, 1'b0, 2'b11, 1'b0, k == 63, "strobe_off");
    end
    // Reset in the middle of the slip wait discards it; relock afterwards.
    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "reset3");
    add(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "rcnt3");
    add(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "bad3");
    add(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, "slip3");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "wait3");
    add(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, "reset_in_wait");
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, "rcnt_after_wait_reset");
    add_clean(64, 1'b0, 1'b1, "relock3");
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, "rcnt_final");
    add(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, "hold_final");

    prev_lock = 1'b0;
    exp_cnt   = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      vld = vecs[i].vld;
      hdr = vecs[i].hdr;
      @(posedge clk);
      #1;
      check1({vecs[i].tag, "/o_slip"}, slip, vecs[i].exp_slip);
      check1({vecs[i].tag, "/o_block_lock"}, lock, vecs[i].exp_lock);
`ifdef RX_BLOCK_LOCK_STATS_EN
      if (vecs[i].rst) exp_cnt = '0;
      else if (vecs[i].exp_slip) exp_cnt = exp_cnt + 16'd1;
      exp_lost = !vecs[i].rst && prev_lock && !vecs[i].exp_lock;
      total++;
      if (slip_count !== exp_cnt) begin
        bad++;
        $display("FAIL %s/o_slip_count: got %0d expected %0d", vecs[i].tag, slip_count, exp_cnt);
      end
      check1({vecs[i].tag, "/o_lock_lost"}, lock_lost, exp_lost);
`endif
      prev_lock = vecs[i].exp_lock;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
